// File: rtl/line_tap_gen.sv
// Three-row tap generator for 3x3 morphology: two line buffers and column/row tracking.
// Optional build macro LINE_TAP_EDGE_REPLICATE_EN replicates the top border rows.
module line_tap_gen #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             frame_done,
  output logic [1:0]       fill_state
);

  localparam int CW = $clog2(PIC_WIDTH);
  localparam int RW = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } fill_t;

  fill_t            state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] buf_a [PIC_WIDTH];
  logic [WIDTH-1:0] buf_b [PIC_WIDTH];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             col_last;
  logic             frame_last;

  assign fill_state = state;

  always_comb begin
    rd_a       = buf_a[col];
    rd_b       = buf_b[col];
    col_last   = (col == COL_LAST);
    frame_last = col_last && (row == ROW_LAST);
  end

  // Line RAMs are not reset; rows shift buf_a -> buf_b on every accepted pixel.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      buf_a[col] <= din;
      buf_b[col] <= rd_a;
    end
  end

  // valid_in qualifies din for exactly one cycle (no backpressure); valid_out
  // qualifies dout1..3 for exactly one cycle, one clock after the matching din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL0;
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      dout1      <= '0;
      dout2      <= '0;
      dout3      <= '0;
    end else if (valid_in) begin
      frame_done <= frame_last;
      dout3      <= din;
      case (state)
        FILL0: begin
`ifdef LINE_TAP_EDGE_REPLICATE_EN
          valid_out <= 1'b1;
          dout1     <= din;
          dout2     <= din;
`else
          valid_out <= 1'b0;
          dout1     <= rd_b;
          dout2     <= rd_a;
`endif
          if (col_last) state <= FILL1;
        end
        FILL1: begin
`ifdef LINE_TAP_EDGE_REPLICATE_EN
          valid_out <= 1'b1;
          dout1     <= rd_a;
          dout2     <= rd_a;
`else
          valid_out <= 1'b0;
          dout1     <= rd_b;
          dout2     <= rd_a;
`endif
          if (col_last) state <= RUN;
        end
        default: begin
          valid_out <= 1'b1;
          dout1     <= rd_b;
          dout2     <= rd_a;
          if (frame_last) state <= FILL0;
        end
      endcase

      if (col_last) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: doc/line_tap_gen.md
# line_tap_gen

Three-row window generator that feeds the 3x3 morphology stages (dilate/erode) in the closing/opening pipelines. It accepts a raster pixel stream, stores the two previous image rows in internal line buffers, and emits three vertically aligned taps per pixel (two rows above, one row above, current row). Downstream stages form the horizontal 3x3 window from these taps. The block tracks column and row position, so it handles the top-of-frame fill and frame wrap-around itself.

## Interface
- WIDTH, 24, pixel width in bits
- PIC_WIDTH, 250, pixels per row (buffer depth, ≥ 2)
- PIC_HEIGHT, 250, rows per frame (≥ 3)

- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- valid_in  input  1  din is a valid pixel this cycle
- din  input  WIDTH  pixel, raster order
- valid_out  output  1  dout1..dout3 hold a valid column triple
- dout1  output  WIDTH  pixel two rows above, same column
- dout2  output  WIDTH  pixel one row above, same column
- dout3  output  WIDTH  current-row pixel (delayed din)
- frame_done  output  1  one-cycle pulse with the last output of a frame

## Operation
- Two line RAMs, buf_a and buf_b, each PIC_WIDTH x WIDTH. Address is col. Reads happen before writes in the same cycle.
- On each valid_in cycle:
  - rd_a = buf_a[col], rd_b = buf_b[col].
  - Then buf_a[col] <= din and buf_b[col] <= rd_a.
  - Registered outputs: dout3 <= din, dout2 <= rd_a, dout1 <= rd_b.
- Counters:
  - col runs 0..PIC_WIDTH-1 and wraps to 0.
  - row increments on col wrap and runs 0..PIC_HEIGHT-1.
  - After row PIC_HEIGHT-1 col PIC_WIDTH-1, both counters go to 0 and the next frame starts.
  - Counters advance only on valid_in.
- Fill FSM, advancing only on a valid_in cycle with col == PIC_WIDTH-1:
  - FILL0: row 0; buffers hold stale data. Goes to FILL1.
  - FILL1: row 1; buf_a holds row 0. Goes to RUN.
  - RUN: rows 2..PIC_HEIGHT-1. On the last pixel of the frame, returns to FILL0.
- valid_out in RUN equals valid_in delayed one cycle. In FILL0/FILL1 it follows the Configuration rules.
- frame_done: registered, asserted with the output produced from the frame's last pixel (row PIC_HEIGHT-1, col PIC_WIDTH-1).
- Stall (valid_in low):
  - Counters, FSM, buffers and dout1..3 hold.
  - valid_out = 0; frame_done = 0.
  - The column position is kept across the gap; it is not reset.
- Line RAM contents are not reset. Stale data never reaches a valid output.

## Timing
- Latency: 1 cycle from a valid_in/din sample to the matching valid_out/dout triple.
- Throughput: 1 pixel per clk; no backpressure.
- Reset values: valid_out=0, dout1=dout2=dout3=0, frame_done=0, col=0, row=0, FSM=FILL0.
- Reset mid-frame: all state above is cleared immediately. The next valid_in is treated as row 0 col 0 of a new frame.
- Last pixel of a frame: the FSM returns to FILL0 in the same edge that registers that pixel. A new frame's first pixel may arrive the very next cycle with no gap.

## Configuration
- Macro: LINE_TAP_EDGE_REPLICATE_EN.
- Defined:
  - Top border is replicated, so output row count = PIC_HEIGHT.
  - FILL0: valid_out follows valid_in, with dout1 = dout2 = dout3 = din.
  - FILL1: valid_out follows valid_in, with dout1 = dout2 = rd_a (row 0), dout3 = din.
- Undefined:
  - valid_out = 0 throughout FILL0 and FILL1.
  - Output row count = PIC_HEIGHT-2 (rows 2..PIC_HEIGHT-1 as dout3).
- frame_done behaviour is identical in both builds.

## Test plan
All scenarios use PIC_WIDTH=4, PIC_HEIGHT=4 and din = 16·row + col (hex).

- Macro undefined, continuous frame:
  - Exactly 8 valid_out pulses.
  - First valid output is one cycle after din=0x20: dout1=0x00, dout2=0x10, dout3=0x20.
  - Last valid output: dout1=0x13, dout2=0x23, dout3=0x33, with frame_done=1.
- Macro defined, continuous frame:
  - Exactly 16 valid_out pulses.
  - Output for din=0x01: all taps 0x01.
  - Output for din=0x12: dout1=dout2=0x02, dout3=0x12.
- Stall:
  - Stimulus: valid_in low for 3 cycles between din=0x21 and din=0x22.
  - During the gap: valid_out=0 and taps hold 0x01/0x11/0x21.
  - Next output: 0x02/0x12/0x22.
- Back-to-back frames:
  - Frame 2 starts the cycle after 0x33.
  - Frame 2 (values + 0x80) repeats the fill sequence.
  - No frame-1 data appears in any valid output except the row-0/1 taps allowed by the macro. With the macro, frame-2 row 0 shows all taps = din.
- Reset mid-frame:
  - Stimulus: rst_n low for 2 cycles after din=0x21.
  - Response: all outputs 0 immediately.
  - Restart with a full frame: valid output count is 8 (or 16 with the macro), and the first RUN triple is 0x00/0x10/0x20.
